// File: rtl/mprj_io_pkg.sv
// Shared constants and helpers for the mprj_io management GPIO controller.
// Register word addresses are 32-bit so they compare cleanly against any address width.
package mprj_io_pkg;

    localparam int NUM_IO_DEFAULT = 38;

    localparam logic [31:0] REG_DATA_LO = 32'd0;
    localparam logic [31:0] REG_DATA_HI = 32'd1;
    localparam logic [31:0] REG_OE_LO   = 32'd2;
    localparam logic [31:0] REG_OE_HI   = 32'd3;
    localparam logic [31:0] REG_SEL_LO  = 32'd4;
    localparam logic [31:0] REG_SEL_HI  = 32'd5;
    localparam logic [31:0] REG_IN_LO   = 32'd6;
    localparam logic [31:0] REG_IN_HI   = 32'd7;
    localparam logic [31:0] REG_CAP_LO  = 32'd8;
    localparam logic [31:0] REG_CAP_HI  = 32'd9;

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[n*8 +: 8] = be[n] ? new_val[n*8 +: 8] : old_val[n*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mprj_io_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, synchronous active-high reset.
module mprj_io_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mprj_io_mgmt_ctrl.sv
// Management-side GPIO controller for the mprj_io bank: register port, per-pin
// owner mux between management and user project, input sync and user_out snapshot.
module mprj_io_mgmt_ctrl
    import mprj_io_pkg::*;
#(
    parameter int NUM_IO = NUM_IO_DEFAULT,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata,
    output logic              ack,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    input  logic [NUM_IO-1:0] user_out,
    input  logic [NUM_IO-1:0] user_oeb
);

    logic [NUM_IO-1:0] data_q;
    logic [NUM_IO-1:0] oe_q;
    logic [NUM_IO-1:0] sel_q;
    logic [NUM_IO-1:0] cap_q;
    logic [NUM_IO-1:0] in_sync;

    logic [31:0] addr_w;
    logic        xfer;
    logic [31:0] rd_word;
    logic [63:0] data_ext;
    logic [63:0] oe_ext;
    logic [63:0] sel_ext;
    logic [63:0] cap_ext;
    logic [63:0] in_ext;

    // A request is only taken while ack is low, so a held req completes every other cycle.
    assign xfer   = req & ~ack;
    assign addr_w = 32'(addr);

    assign data_ext = 64'(data_q);
    assign oe_ext   = 64'(oe_q);
    assign sel_ext  = 64'(sel_q);
    assign cap_ext  = 64'(cap_q);
    assign in_ext   = 64'(in_sync);

    mprj_io_sync2 #(
        .WIDTH(NUM_IO)
    ) u_in_sync (
        .clk (clk),
        .rst (rst),
        .d   (io_in),
        .q   (in_sync)
    );

    // Bits above NUM_IO in the HI word are dropped on write, so they always read back 0.
    function automatic logic [NUM_IO-1:0] reg_write(
        input logic [NUM_IO-1:0] cur,
        input logic              hi,
        input logic [31:0]       d,
        input logic [3:0]        b
    );
        logic [63:0] w;
        w = 64'(cur);
        if (hi) begin
            w[63:32] = be_merge(w[63:32], d, b);
        end else begin
            w[31:0] = be_merge(w[31:0], d, b);
        end
        return w[NUM_IO-1:0];
    endfunction

    always_comb begin
        rd_word = '0;
        case (addr_w)
            REG_DATA_LO: rd_word = data_ext[31:0];
            REG_DATA_HI: rd_word = data_ext[63:32];
            REG_OE_LO:   rd_word = oe_ext[31:0];
            REG_OE_HI:   rd_word = oe_ext[63:32];
            REG_SEL_LO:  rd_word = sel_ext[31:0];
            REG_SEL_HI:  rd_word = sel_ext[63:32];
            REG_IN_LO:   rd_word = in_ext[31:0];
            REG_IN_HI:   rd_word = in_ext[63:32];
            REG_CAP_LO:  rd_word = cap_ext[31:0];
            REG_CAP_HI:  rd_word = cap_ext[63:32];
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack    <= 1'b0;
            rdata  <= '0;
            data_q <= '0;
            oe_q   <= '0;
            sel_q  <= '0;
            cap_q  <= '0;
        end else begin
            ack   <= xfer;
            rdata <= (xfer && !we) ? rd_word : '0;
            if (xfer && we) begin
                if (addr_w == REG_DATA_LO || addr_w == REG_DATA_HI) begin
                    data_q <= reg_write(data_q, addr_w[0], wdata, be);
                end
                if (addr_w == REG_OE_LO || addr_w == REG_OE_HI) begin
                    oe_q <= reg_write(oe_q, addr_w[0], wdata, be);
                end
                if (addr_w == REG_SEL_LO || addr_w == REG_SEL_HI) begin
                    sel_q <= reg_write(sel_q, addr_w[0], wdata, be);
                end
                // Snapshot ignores data and byte enables: any write captures every pin.
                if (addr_w == REG_CAP_LO || addr_w == REG_CAP_HI) begin
                    cap_q <= user_out;
                end
            end
        end
    end

    assign io_out = (sel_q & user_out) | (~sel_q & data_q);
    assign io_oeb = (sel_q & user_oeb) | (~sel_q & ~oe_q);

endmodule

// File: tb/tb_mprj_io_mgmt_ctrl.sv
// Self-checking bench for mprj_io_mgmt_ctrl: directed vector table, handshake corner
// sequences, then random traffic compared against a register-level reference model.
module tb_mprj_io_mgmt_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [37:0] user_out;
    logic [37:0] user_oeb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [37:0] ack_out;
    logic [37:0] ack_oeb;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [37:0] uo;
        logic [31:0] er;
        logic [37:0] eo;
        logic [37:0] eoeb;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: one 64-bit word per register pair
    logic [63:0] m_data, m_oe, m_sel, m_cap;
    localparam logic [63:0] PIN_MASK = 64'h0000_003F_FFFF_FFFF;

    mprj_io_mgmt_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .rdata    (rdata),
        .ack      (ack),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .user_out (user_out),
        .user_oeb (user_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the ack cycle.
    task automatic do_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] rd);
        int  cyc;
        bit  got;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        cyc   = 0;
        got   = 0;
        while (!got && cyc < 4) begin
            @(negedge clk);
            cyc++;
            if (ack) got = 1;
        end
        chk("ack_latency", 64'(cyc), 64'd1);
        rd      = rdata;
        ack_out = io_out;
        ack_oeb = io_oeb;
        req = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        chk("ack_single_cycle", {63'd0, ack}, 64'd0);
        chk("rdata_idle_zero", 64'(rdata), 64'd0);
    endtask

    task automatic add(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [37:0] uo, input logic [31:0] er,
                       input logic [37:0] eo, input logic [37:0] eoeb);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.b = b; v.uo = uo; v.er = er; v.eo = eo; v.eoeb = eoeb;
        tbl.push_back(v);
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [63:0] r;
        int          base;
        base = (a % 2) * 32;
        if (a < 6) begin
            r = (a < 2) ? m_data : (a < 4) ? m_oe : m_sel;
            for (int n = 0; n < 4; n++) begin
                if (b[n]) r[base + n*8 +: 8] = d[n*8 +: 8];
            end
            r = r & PIN_MASK;
            if (a < 2) m_data = r;
            else if (a < 4) m_oe = r;
            else m_sel = r;
        end else if (a == 8 || a == 9) begin
            m_cap = 64'(user_out);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [63:0] r;
        case (a)
            0, 1:    r = m_data;
            2, 3:    r = m_oe;
            4, 5:    r = m_sel;
            6, 7:    r = 64'(io_in);
            8, 9:    r = m_cap;
            default: return 32'd0;
        endcase
        return (a % 2 == 1) ? r[63:32] : r[31:0];
    endfunction

    task automatic model_pads(output logic [37:0] eo, output logic [37:0] eoeb);
        for (int i = 0; i < 38; i++) begin
            if (m_sel[i]) begin
                eo[i]   = user_out[i];
                eoeb[i] = user_oeb[i];
            end else begin
                eo[i]   = m_data[i];
                eoeb[i] = !m_oe[i];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [37:0] eo, eoeb;
        logic        w;
        logic [3:0]  a, b;
        logic [31:0] d;
        logic [63:0] rnd;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        io_in = '0; user_out = '0; user_oeb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("reset_io_out", 64'(io_out), 64'd0);
        chk("reset_ack", {63'd0, ack}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'b0, 4'(i), 32'd0, 4'h0, rd);
            chk($sformatf("reset_read_%0d", i), 64'(rd), 64'd0);
        end

        // w  addr data          be    user_out           rdata         io_out             io_oeb
        add(1, 2,  32'hFFFF0000, 4'hF, 38'h0,             32'h0,        38'h00_0000_0000, 38'h3F_0000_FFFF);
        add(1, 0,  32'hAB400000, 4'hF, 38'h0,             32'h0,        38'h00_AB40_0000, 38'h3F_0000_FFFF);
        add(1, 3,  32'h0000000F, 4'hF, 38'h0,             32'h0,        38'h00_AB40_0000, 38'h30_0000_FFFF);
        add(1, 1,  32'h0000000A, 4'hF, 38'h0,             32'h0,        38'h0A_AB40_0000, 38'h30_0000_FFFF);
        add(1, 1,  32'h00000005, 4'hF, 38'h0,             32'h0,        38'h05_AB40_0000, 38'h30_0000_FFFF);
        add(1, 4,  32'h0000FFFF, 4'hF, 38'h00_0000_1968,  32'h0,        38'h05_AB40_1968, 38'h30_0000_0000);
        add(1, 8,  32'h00000000, 4'hF, 38'h00_0000_1968,  32'h0,        38'h05_AB40_1968, 38'h30_0000_0000);
        add(0, 8,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h00001968, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(1, 0,  32'h19680000, 4'hF, 38'h00_0000_1DCD,  32'h0,        38'h05_1968_1DCD, 38'h30_0000_0000);
        add(1, 0,  32'hAB400000, 4'hF, 38'h00_0000_1DCD,  32'h0,        38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(1, 0,  32'hFFFFFFFF, 4'h1, 38'h00_0000_1DCD,  32'h0,        38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 0,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'hAB4000FF, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 1,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h00000005, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 2,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'hFFFF0000, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 3,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h0000000F, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 4,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h0000FFFF, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(1, 5,  32'hFFFFFFC0, 4'hF, 38'h00_0000_1DCD,  32'h0,        38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 5,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h00000000, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 12, 32'h0,        4'h0, 38'h00_0000_1DCD,  32'h00000000, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(1, 13, 32'hFFFFFFFF, 4'hF, 38'h00_0000_1DCD,  32'h0,        38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 9,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h00000000, 38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(1, 9,  32'h00000000, 4'hF, 38'h2A_0000_1DCD,  32'h0,        38'h05_AB40_1DCD, 38'h30_0000_0000);
        add(0, 9,  32'h0,        4'h0, 38'h00_0000_1DCD,  32'h0000002A, 38'h05_AB40_1DCD, 38'h30_0000_0000);

        foreach (tbl[k]) begin
            user_out = tbl[k].uo;
            do_xfer(tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].b, rd);
            if (!tbl[k].w) chk($sformatf("tbl%0d_rdata", k), 64'(rd), 64'(tbl[k].er));
            chk($sformatf("tbl%0d_io_out", k), 64'(ack_out), 64'(tbl[k].eo));
            chk($sformatf("tbl%0d_io_oeb", k), 64'(ack_oeb), 64'(tbl[k].eoeb));
        end

        // Held req: ack pattern 1,0,1 because req is not re-sampled during ack
        req = 1'b1; we = 1'b0; addr = 4'd2;
        @(negedge clk); chk("b2b_ack0", {63'd0, ack}, 64'd1);
        @(negedge clk); chk("b2b_ack1", {63'd0, ack}, 64'd0);
        @(negedge clk); chk("b2b_ack2", {63'd0, ack}, 64'd1);
        chk("b2b_rdata", 64'(rdata), 64'hFFFF0000);
        req = 1'b0;
        @(negedge clk);

        // Pad inputs through the synchroniser
        io_in[3]  = 1'b1;
        io_in[37] = 1'b1;
        repeat (3) @(negedge clk);
        do_xfer(1'b0, 4'd6, 32'd0, 4'h0, rd);
        chk("in_lo_pin3", 64'(rd), 64'h8);
        do_xfer(1'b0, 4'd7, 32'd0, 4'h0, rd);
        chk("in_hi_pin37", 64'(rd), 64'h20);
        io_in = '0;
        repeat (3) @(negedge clk);

        // Reset arriving on the same edge as a write request
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 32'hFFFFFFFF; be = 4'hF;
        @(negedge clk);
        chk("rst_mid_no_ack", {63'd0, ack}, 64'd0);
        rst = 1'b0; req = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_ack2", {63'd0, ack}, 64'd0);
        user_out = '0;
        chk("rst_mid_io_out", 64'(io_out), 64'd0);
        chk("rst_mid_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        do_xfer(1'b0, 4'd0, 32'd0, 4'h0, rd);
        chk("rst_mid_data_lo", 64'(rd), 64'd0);

        // Random traffic against the reference model
        m_data = '0; m_oe = '0; m_sel = '0; m_cap = '0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd   = {$urandom(), $urandom()};
                io_in = rnd[37:0];
                repeat (3) @(negedge clk);
            end
            rnd      = {$urandom(), $urandom()};
            user_out = rnd[37:0];
            rnd      = {$urandom(), $urandom()};
            user_oeb = rnd[37:0];
            w = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = $urandom();
            b = 4'($urandom_range(0, 15));
            if (w) model_write(a, d, b);
            do_xfer(w, a, d, b, rd);
            if (!w) chk($sformatf("rnd%0d_rdata_a%0d", it, a), 64'(rd), 64'(model_read(a)));
            model_pads(eo, eoeb);
            chk($sformatf("rnd%0d_io_out", it), 64'(ack_out), 64'(eo));
            chk($sformatf("rnd%0d_io_oeb", it), 64'(ack_oeb), 64'(eoeb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
